reg_timer: RTL and testbench

REG_TIMER -- requirements
Module: reg_timer

---
 rtl/reg_timer_pkg.sv | 59 +++++
 rtl/reg_bus.sv | 17 +
 rtl/reg_timer_prescaler.sv | 27 ++
 rtl/reg_timer.sv | 148 ++++++++++++++
 tb/tb_reg_timer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_timer_pkg.sv
// Register map, CTRL/STATUS field positions and access helpers for reg_timer.
package reg_timer_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_COUNT_LO = 5'h08;
  localparam logic [4:0] OFF_COUNT_HI = 5'h0C;
  localparam logic [4:0] OFF_CMP_LO   = 5'h10;
  localparam logic [4:0] OFF_CMP_HI   = 5'h14;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT     = 2;
  localparam int CTRL_PRESCALE_LSB   = 8;
  localparam int CTRL_PRESCALE_MSB   = 15;
  localparam int PRESCALE_W          = CTRL_PRESCALE_MSB - CTRL_PRESCALE_LSB + 1;

  localparam int STATUS_PEND_BIT = 0;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_COUNT_LO,
    SEL_COUNT_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_ERR
  } reg_sel_e;

  // Misaligned offsets and offsets past CMP_HI both land on SEL_ERR.
  function automatic reg_sel_e decode_offset(input logic [4:0] off);
    reg_sel_e sel;
    sel = SEL_ERR;
    if (off[1:0] == 2'b00) begin
      case (off)
        OFF_CTRL:     sel = SEL_CTRL;
        OFF_STATUS:   sel = SEL_STATUS;
        OFF_COUNT_LO: sel = SEL_COUNT_LO;
        OFF_COUNT_HI: sel = SEL_COUNT_HI;
        OFF_CMP_LO:   sel = SEL_CMP_LO;
        OFF_CMP_HI:   sel = SEL_CMP_HI;
        default:      sel = SEL_ERR;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bus.sv
// Simple register bus: master holds valid until ready, slave answers with rdata/error.
interface REG_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    error;
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   rdata;

  modport Master (output addr, write, wdata, wstrb, valid, input rdata, error, ready);
  modport Slave  (input addr, write, wdata, wstrb, valid, output rdata, error, ready);
endinterface

// File: rtl/reg_timer_prescaler.sv
// Prescaler: counts 0..prescale_i while enabled and pulses tick_o for one cycle at the top.
// Held at 0 while disabled, so the first tick after enabling arrives prescale_i+1 cycles later.
module reg_timer_prescaler
  import reg_timer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= rather than == so lowering PRESCALE below the running count cannot strand it.
  always_comb begin
    tick_o = en_i & (cnt_q >= prescale_i);
    cnt_d  = '0;
    if (en_i && !tick_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_timer.sv
// 64-bit compare timer with REG_BUS slave; every access takes 2 cycles (one wait state).
// Ready comes from a registered pending flag; an abandoned or reset-aborted request has no effect.
module reg_timer
  import reg_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic  clk_i,
  input  logic  rst_i,
  REG_BUS.Slave reg_i,
  output logic  irq_o
);

  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    unused_addr;

  assign addr        = reg_i.addr;
  assign wdata       = reg_i.wdata;
  assign wstrb       = reg_i.wstrb;
  assign unused_addr = ^addr[ADDR_WIDTH-1:5];

  logic                  req_pend_q, req_pend_d;
  logic                  en_q, en_d;
  logic                  autoreload_q, autoreload_d;
  logic                  irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  pend_q, pend_d;
  logic [63:0]           count_q, count_d;
  logic [63:0]           cmp_q, cmp_d;
  logic [31:0]           shadow_q, shadow_d;

  logic        tick;
  reg_sel_e    sel;
  logic        addr_err, access, wr_en, rd_en;
  logic [31:0] ctrl_rd, ctrl_wr, status_wr, rd_mux;
  logic [63:0] count_tick;
  logic        match, pend_set, pend_clr;

  reg_timer_prescaler u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_q),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  assign sel      = decode_offset(addr[4:0]);
  assign addr_err = (sel == SEL_ERR);
  assign access   = reg_i.valid & req_pend_q & ~rst_i;
  assign wr_en    = access & reg_i.write & ~addr_err;
  assign rd_en    = access & ~reg_i.write & ~addr_err;

  // Set on the first valid cycle, always dropped the next: completion and abandonment look alike.
  assign req_pend_d  = reg_i.valid & ~req_pend_q;
  assign reg_i.ready = req_pend_q & ~rst_i;
  assign reg_i.error = reg_i.ready & addr_err;
  assign reg_i.rdata = (reg_i.ready && !addr_err) ? rd_mux : '0;

  assign irq_o = pend_q & irq_en_q & ~rst_i;

  always_comb begin
    ctrl_rd                                          = '0;
    ctrl_rd[CTRL_EN_BIT]                             = en_q;
    ctrl_rd[CTRL_AUTORELOAD_BIT]                     = autoreload_q;
    ctrl_rd[CTRL_IRQ_EN_BIT]                         = irq_en_q;
    ctrl_rd[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]     = prescale_q;
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_CTRL:     rd_mux = ctrl_rd;
      SEL_STATUS:   rd_mux = {31'b0, pend_q};
      SEL_COUNT_LO: rd_mux = count_q[31:0];
      SEL_COUNT_HI: rd_mux = shadow_q;
      SEL_CMP_LO:   rd_mux = cmp_q[31:0];
      SEL_CMP_HI:   rd_mux = cmp_q[63:32];
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    en_d         = en_q;
    autoreload_d = autoreload_q;
    irq_en_d     = irq_en_q;
    prescale_d   = prescale_q;
    cmp_d        = cmp_q;
    shadow_d     = shadow_q;
    ctrl_wr      = apply_wstrb(ctrl_rd, wdata, wstrb);
    status_wr    = apply_wstrb(32'h0, wdata, wstrb);
    pend_clr     = 1'b0;

    match      = (count_q == cmp_q);
    count_tick = (match && autoreload_q) ? 64'd0 : count_q + 64'd1;
    count_d    = tick ? count_tick : count_q;
    pend_set   = tick & match;

    // Software writes overwrite only their own half of the tick-updated count.
    if (wr_en) begin
      case (sel)
        SEL_CTRL: begin
          en_d         = ctrl_wr[CTRL_EN_BIT];
          autoreload_d = ctrl_wr[CTRL_AUTORELOAD_BIT];
          irq_en_d     = ctrl_wr[CTRL_IRQ_EN_BIT];
          prescale_d   = ctrl_wr[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        end
        SEL_STATUS:   pend_clr       = status_wr[STATUS_PEND_BIT];
        SEL_COUNT_LO: count_d[31:0]  = apply_wstrb(count_q[31:0], wdata, wstrb);
        SEL_COUNT_HI: count_d[63:32] = apply_wstrb(count_q[63:32], wdata, wstrb);
        SEL_CMP_LO:   cmp_d[31:0]    = apply_wstrb(cmp_q[31:0], wdata, wstrb);
        SEL_CMP_HI:   cmp_d[63:32]   = apply_wstrb(cmp_q[63:32], wdata, wstrb);
        default: ;
      endcase
    end

    if (rd_en && sel == SEL_COUNT_LO) shadow_d = count_q[63:32];

    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pend_q   <= 1'b0;
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      prescale_q   <= '0;
      pend_q       <= 1'b0;
      count_q      <= '0;
      cmp_q        <= '1;
      shadow_q     <= '0;
    end else begin
      req_pend_q   <= req_pend_d;
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      irq_en_q     <= irq_en_d;
      prescale_q   <= prescale_d;
      pend_q       <= pend_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      shadow_q     <= shadow_d;
    end
  end

endmodule

// File: tb/tb_reg_timer.sv
// Directed bench for reg_timer: hand-computed expectations checked with immediate assertions.
module tb_reg_timer;

  logic clk_i = 1'b0;
  logic rst_i;
  logic irq_o;
  int   checks = 0;
  int   errors = 0;

  REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  reg_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .reg_i (bus),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
    int lat;
    bus.valid = 1'b1;
    bus.write = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = s;
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (bus.ready === 1'b1) begin
        lat = i;
        rd  = bus.rdata;
        er  = bus.error;
      end
      @(posedge clk_i);
      #1;
    end
    bus.valid = 1'b0;
    bus.write = 1'b0;
    chk($sformatf("latency_%0h", a), 64'(lat), 64'd2);
  endtask

  task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic        e;
    xfer(1'b1, a, d, s, r, e);
    chk($sformatf("wr_err_%0h", a), 64'(e), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    xfer(1'b0, a, 32'h0, 4'h0, r, e);
    chk(tag, 64'(r), 64'(exp));
    chk({tag, "_err"}, 64'(e), 64'd0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [31:0] a);
    logic [31:0] r;
    logic        e;
    xfer(w, a, 32'hA5A5_A5A5, 4'hF, r, e);
    chk({tag, "_error"}, 64'(e), 64'd1);
    chk({tag, "_rdata"}, 64'(r), 64'd0);
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    rst_i     = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    // Request presented while reset is held: nothing answers.
    bus.valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 64'(bus.ready), 64'd0);
      chk("rst_error", 64'(bus.error), 64'd0);
      chk("rst_rdata", 64'(bus.rdata), 64'd0);
      chk("rst_irq",   64'(irq_o),     64'd0);
      @(posedge clk_i);
      #1;
    end
    bus.valid = 1'b0;
    rst_i     = 1'b0;

    rd_chk("ctrl_reset",   32'h00, 32'h0);
    rd_chk("status_reset", 32'h04, 32'h0);
    rd_chk("cmplo_reset",  32'h10, 32'hFFFF_FFFF);
    rd_chk("cmphi_reset",  32'h14, 32'hFFFF_FFFF);
    rd_chk("cntlo_reset",  32'h08, 32'h0);

    // Free-running, PRESCALE=0: count advances every cycle.
    wr_chk(32'h00, 32'h0000_0001, 4'hF);
    rd_chk("cnt_run_a", 32'h08, 32'd1);
    rd_chk("cnt_run_b", 32'h08, 32'd3);

    // PRESCALE=3: one increment every 4 cycles.
    wr_chk(32'h00, 32'h0000_0300, 4'hF);
    wr_chk(32'h08, 32'h0, 4'hF);
    wr_chk(32'h0C, 32'h0, 4'hF);
    wr_chk(32'h00, 32'h0000_0301, 4'hF);
    rd_chk("psc3_a", 32'h08, 32'd0);
    rd_chk("psc3_b", 32'h08, 32'd0);
    rd_chk("psc3_c", 32'h08, 32'd1);
    rd_chk("psc3_d", 32'h08, 32'd1);
    rd_chk("psc3_e", 32'h08, 32'd2);

    // CMP=5 with autoreload and interrupt enabled.
    wr_chk(32'h00, 32'h0, 4'hF);
    wr_chk(32'h14, 32'h0, 4'hF);
    wr_chk(32'h10, 32'd5, 4'hF);
    wr_chk(32'h08, 32'h0, 4'hF);
    wr_chk(32'h00, 32'h0000_0007, 4'hF);
    rd_chk("ar_cnt_a",     32'h08, 32'd1);
    rd_chk("ar_cnt_b",     32'h08, 32'd3);
    rd_chk("ar_pend_pre",  32'h04, 32'd0);
    rd_chk("ar_pend_set",  32'h04, 32'd1);
    chk("ar_irq_set", 64'(irq_o), 64'd1);
    rd_chk("ar_cnt_reload", 32'h08, 32'd3);
    wr_chk(32'h04, 32'h1, 4'hF);
    chk("w1c_vs_match_irq", 64'(irq_o), 64'd1);
    wr_chk(32'h04, 32'h1, 4'hF);
    chk("w1c_irq_clear", 64'(irq_o), 64'd0);
    rd_chk("w1c_pend_clear", 32'h04, 32'd0);

    // Low/high coherency around the 32-bit carry.
    wr_chk(32'h00, 32'h0, 4'hF);
    wr_chk(32'h0C, 32'h0, 4'hF);
    wr_chk(32'h08, 32'hFFFF_FFFE, 4'hF);
    wr_chk(32'h00, 32'h0000_0001, 4'hF);
    rd_chk("carry_lo",      32'h08, 32'hFFFF_FFFF);
    rd_chk("carry_hi_shdw", 32'h0C, 32'h0);
    rd_chk("carry_lo_next", 32'h08, 32'd3);
    rd_chk("carry_hi_next", 32'h0C, 32'd1);
    wr_chk(32'h08, 32'h0000_0100, 4'hF);
    rd_chk("swwr_lo", 32'h08, 32'h0000_0101);
    rd_chk("swwr_hi", 32'h0C, 32'd1);

    // Decode errors have no side effects.
    wr_chk(32'h00, 32'h0, 4'hF);
    wr_chk(32'h08, 32'h0000_1234, 4'hF);
    wr_chk(32'h0C, 32'h0, 4'hF);
    err_chk("rd_18", 1'b0, 32'h18);
    err_chk("rd_02", 1'b0, 32'h02);
    err_chk("wr_18", 1'b1, 32'h18);
    err_chk("wr_02", 1'b1, 32'h02);
    rd_chk("noeff_ctrl",  32'h00, 32'h0);
    rd_chk("noeff_cntlo", 32'h08, 32'h0000_1234);
    rd_chk("noeff_cnthi", 32'h0C, 32'h0);
    rd_chk("noeff_cmplo", 32'h10, 32'd5);
    rd_chk("noeff_cmphi", 32'h14, 32'h0);

    // Byte strobes and reserved CTRL bits.
    wr_chk(32'h10, 32'hAABB_CCDD, 4'b0010);
    rd_chk("strb_cmplo", 32'h10, 32'h0000_CC05);
    wr_chk(32'h00, 32'hFFFF_FFF8, 4'hF);
    rd_chk("ctrl_rsvd", 32'h00, 32'h0000_FF00);

    // Request abandoned after one cycle leaves CTRL untouched.
    bus.valid = 1'b1;
    bus.write = 1'b1;
    bus.addr  = 32'h00;
    bus.wdata = 32'h0000_0001;
    bus.wstrb = 4'hF;
    @(posedge clk_i);
    #1;
    bus.valid = 1'b0;
    bus.write = 1'b0;
    @(posedge clk_i);
    #1;
    chk("abandon_ready", 64'(bus.ready), 64'd0);
    rd_chk("abandon_ctrl", 32'h00, 32'h0000_FF00);

    // Reset lands in the ready cycle of a CMP_LO write.
    bus.valid = 1'b1;
    bus.write = 1'b1;
    bus.addr  = 32'h10;
    bus.wdata = 32'h0000_0077;
    bus.wstrb = 4'hF;
    chk("mid_c1_ready", 64'(bus.ready), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus.ready), 64'd0);
    @(posedge clk_i);
    #1;
    chk("mid_rst_ready2", 64'(bus.ready), 64'd0);
    bus.valid = 1'b0;
    bus.write = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rd_chk("post_rst_cmplo", 32'h10, 32'hFFFF_FFFF);
    rd_chk("post_rst_ctrl",  32'h00, 32'h0);
    rd_chk("post_rst_cntlo", 32'h08, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
